post_adder_acc: RTL and testbench

POST_ADDER_ACC -- requirements
Module: post_adder_acc

---
 rtl/post_adder_acc.sv | 101 ++++++++++
 tb/tb_post_adder_acc.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/post_adder_acc.sv
// 48-bit post-adder/accumulator: X/Z operand muxes, add/subtract with carry-in,
// internal P and carry-out registers with optional combinational output bypass.
module post_adder_acc #(
    parameter int    PREG        = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CEP,
    input  logic        CEOPMODE,
    input  logic [7:0]  opmode,
    input  logic [35:0] M,
    input  logic [47:0] DAB,
    input  logic [47:0] C,
    input  logic [47:0] PCIN,
    input  logic        CARRYIN,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic        CARRYOUT,
    output logic        CARRYOUTF
);

    typedef enum logic [1:0] {X_ZERO, X_M, X_P, X_DAB} x_sel_e;
    typedef enum logic [1:0] {Z_ZERO, Z_PCIN, Z_P, Z_C} z_sel_e;

    localparam bit USE_CARRYIN = (CARRYINSEL == "CARRYIN");

    logic [7:0]  opmode_q;
    logic [7:0]  op;
    logic [47:0] p_q;
    logic        co_q;
    logic [47:0] x_val;
    logic [47:0] z_val;
    logic        cin;
    logic [48:0] result;
    logic        unused_op_bits;

    // NOTE: every register below uses non-blocking assignments so all state
    // updates on an edge see the pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            opmode_q <= '0;
        end else if (CEOPMODE) begin
            opmode_q <= opmode;
        end
    end

    assign op             = (OPMODEREG != 0) ? opmode_q : opmode;
    assign cin            = USE_CARRYIN ? CARRYIN : op[5];
    assign unused_op_bits = &{1'b0, op[4], op[6]};

    // Feedback always taps p_q, never the combinational result, so PREG=0 has no loop.
    always_comb begin
        x_val = '0;
        case (x_sel_e'(op[1:0]))
            X_ZERO:  x_val = '0;
            X_M:     x_val = {12'b0, M};
            X_P:     x_val = p_q;
            X_DAB:   x_val = DAB;
            default: x_val = '0;
        endcase
    end

    always_comb begin
        z_val = '0;
        case (z_sel_e'(op[3:2]))
            Z_ZERO:  z_val = '0;
            Z_PCIN:  z_val = PCIN;
            Z_P:     z_val = p_q;
            Z_C:     z_val = C;
            default: z_val = '0;
        endcase
    end

    // Bit 48 is the carry on add and the borrow on subtract.
    always_comb begin
        if (op[7]) begin
            result = {1'b0, z_val} - {1'b0, x_val} - {48'b0, cin};
        end else begin
            result = {1'b0, z_val} + {1'b0, x_val} + {48'b0, cin};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q  <= '0;
            co_q <= 1'b0;
        end else if (CEP) begin
            p_q  <= result[47:0];
            co_q <= result[48];
        end
    end

    assign P         = (PREG != 0) ? p_q : result[47:0];
    assign PCOUT     = P;
    assign CARRYOUT  = (CARRYOUTREG != 0) ? co_q : result[48];
    assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_post_adder_acc.sv
// Scoreboard bench for post_adder_acc: a fully registered instance and a fully
// combinational instance (external carry-in) run side by side on shared stimulus.
module tb_post_adder_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        cep = 1'b0;
    logic        ceop = 1'b0;
    logic        carryin = 1'b0;
    logic [7:0]  opmode = '0;
    logic [35:0] m = '0;
    logic [47:0] dab = '0;
    logic [47:0] c = '0;
    logic [47:0] pcin = '0;

    logic [47:0] p_a, pcout_a, p_b, pcout_b;
    logic        co_a, cof_a, co_b, cof_b;

    post_adder_acc #(.PREG(1), .CARRYOUTREG(1), .OPMODEREG(1), .CARRYINSEL("OPMODE5")) dut_a (
        .clk(clk), .rst(rst), .CEP(cep), .CEOPMODE(ceop), .opmode(opmode), .M(m),
        .DAB(dab), .C(c), .PCIN(pcin), .CARRYIN(carryin),
        .P(p_a), .PCOUT(pcout_a), .CARRYOUT(co_a), .CARRYOUTF(cof_a)
    );

    post_adder_acc #(.PREG(0), .CARRYOUTREG(0), .OPMODEREG(0), .CARRYINSEL("CARRYIN")) dut_b (
        .clk(clk), .rst(rst), .CEP(cep), .CEOPMODE(ceop), .opmode(opmode), .M(m),
        .DAB(dab), .C(c), .PCIN(pcin), .CARRYIN(carryin),
        .P(p_b), .PCOUT(pcout_b), .CARRYOUT(co_b), .CARRYOUTF(cof_b)
    );

    typedef struct {
        logic [47:0] p_a;
        logic        co_a;
        logic [47:0] p_b;
        logic        co_b;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: accumulator value, carry flag and captured opmode.
    logic [47:0] mp_a = '0;
    logic [47:0] mp_b = '0;
    logic        mco_a = 1'b0;
    logic        mco_b = 1'b0;
    logic [7:0]  mop_a = '0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Plain integer arithmetic: returns {carry_or_borrow, 48-bit result}.
    function automatic logic [48:0] model_calc(input logic [7:0] op, input logic [47:0] fb,
                                               input logic cin_bit);
        longint x, z, t, ci, lim;
        lim = 64'h0001_0000_0000_0000;
        ci  = cin_bit ? 1 : 0;
        case (op[1:0])
            2'd0: x = 0;
            2'd1: x = longint'(m);
            2'd2: x = longint'(fb);
            default: x = longint'(dab);
        endcase
        case (op[3:2])
            2'd0: z = 0;
            2'd1: z = longint'(pcin);
            2'd2: z = longint'(fb);
            default: z = longint'(c);
        endcase
        if (op[7]) begin
            t = z - x - ci;
            return {t < 0, t[47:0]};
        end
        t = z + x + ci;
        return {t >= lim, t[47:0]};
    endfunction

    // Advance the reference across the coming edge and queue the expected outputs.
    task automatic model_step();
        logic [48:0] r;
        exp_t        e;
        r = model_calc(mop_a, mp_a, mop_a[5]);
        if (rst) begin
            mp_a = '0; mco_a = 1'b0; mop_a = '0;
        end else begin
            if (cep) {mco_a, mp_a} = r;
            if (ceop) mop_a = opmode;
        end
        r = model_calc(opmode, mp_b, carryin);
        if (rst) begin
            mp_b = '0; mco_b = 1'b0;
        end else if (cep) begin
            {mco_b, mp_b} = r;
        end
        r = model_calc(opmode, mp_b, carryin);
        e.p_a = mp_a; e.co_a = mco_a; e.p_b = r[47:0]; e.co_b = r[48];
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic ce_p, input logic ce_op, input logic [7:0] op,
                         input logic [35:0] mv, input logic [47:0] dv, input logic [47:0] cv,
                         input logic [47:0] pv, input logic ci);
        @(negedge clk);
        rst = r; cep = ce_p; ceop = ce_op; opmode = op;
        m = mv; dab = dv; c = cv; pcin = pv; carryin = ci;
        model_step();
    endtask

    function automatic logic [47:0] rand48();
        logic [63:0] r64;
        r64 = {$urandom(), $urandom()};
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 48'd1;
            default: return r64[47:0];
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("p_a", p_a, e.p_a);
                check("pcout_a", pcout_a, e.p_a);
                check("co_a", {47'b0, co_a}, {47'b0, e.co_a});
                check("cof_a", {47'b0, cof_a}, {47'b0, e.co_a});
                check("p_b", p_b, e.p_b);
                check("pcout_b", pcout_b, e.p_b);
                check("co_b", {47'b0, co_b}, {47'b0, e.co_b});
                check("cof_b", {47'b0, cof_b}, {47'b0, e.co_b});
            end
        end
    end

    initial begin : driver
        logic [63:0] r64;
        // Reset, then load 0x1234 and clear it with CEP low.
        repeat (2) drive(1, 0, 0, 8'h00, 36'd0, 48'd0, 48'd0, 48'd0, 0);
        repeat (2) drive(0, 1, 1, 8'h0C, 36'd0, 48'd0, 48'h1234, 48'd0, 0);
        drive(1, 0, 0, 8'h0C, 36'd0, 48'd0, 48'h1234, 48'd0, 0);
        // Multiply-add 1000 + 24.
        repeat (2) drive(0, 1, 1, 8'h0D, 36'd1000, 48'd0, 48'd24, 48'd0, 0);
        // Accumulate M=5 from zero, then hold.
        drive(1, 0, 0, 8'h09, 36'd5, 48'd0, 48'd0, 48'd0, 0);
        repeat (5) drive(0, 1, 1, 8'h09, 36'd5, 48'd0, 48'd0, 48'd0, 0);
        drive(0, 0, 1, 8'h09, 36'd5, 48'd0, 48'd0, 48'd0, 0);
        // Subtract with borrow: 3 - 5.
        repeat (2) drive(0, 1, 1, 8'h8F, 36'd0, 48'd5, 48'd3, 48'd0, 0);
        // Carry wrap: all-ones + carry-in.
        repeat (2) drive(0, 1, 1, 8'h2C, 36'd0, 48'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 1);
        // Opmode latency: 0x0C then 0x0D with M=7, C=1.
        repeat (2) drive(0, 1, 1, 8'h0C, 36'd7, 48'd0, 48'd1, 48'd0, 0);
        repeat (2) drive(0, 1, 1, 8'h0D, 36'd7, 48'd0, 48'd1, 48'd0, 0);
        // Reset wins over both enables.
        drive(1, 1, 1, 8'hFF, 36'd9, 48'd9, 48'd9, 48'd9, 1);
        // Randomized traffic with occasional resets and enable drops.
        for (int i = 0; i < 400; i++) begin
            r64 = {$urandom(), $urandom()};
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  8'($urandom()), r64[35:0], rand48(), rand48(), rand48(), 1'($urandom()));
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 48'(sb.size()), 48'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
